lock_key_loader: RTL and testbench

- Upstream key-provisioning stage for the RLL-locked combinational benchmarks.
- Receives a serial key frame: KEY_WIDTH data bits LSB first, then one even-parity bit.
- Checks parity, then commits the key in parallel onto the locked core's keyIn_0_* bus. The core never sees a partial or corrupt key.
- Counts consecutive failed loads and locks out permanently (until reset) after MAX_FAIL failures.

---
 rtl/lock_key_loader.sv | 159 +++++++++++++++
 tb/tb_lock_key_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_key_loader.sv
// Serial key-frame loader: shifts KEY_WIDTH bits LSB first plus an even-parity bit,
// commits a verified key in parallel and locks out after MAX_FAIL consecutive failures.
module lock_key_loader #(
  parameter int KEY_WIDTH = 32,
  parameter int MAX_FAIL  = 3,
  parameter int CNT_W     = $clog2(KEY_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 key_sdi,
  input  logic                 key_svalid,
  output logic                 key_sready,
  input  logic                 zeroize,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 load_ok,
  output logic                 load_err,
  output logic                 locked_out
);

  localparam int FAIL_W = (MAX_FAIL < 2) ? 1 : $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY,
    S_CHECK,
    S_LOCKOUT
  } state_t;

  state_t                state_reg, state_next;
  logic [KEY_WIDTH-1:0]  shadow_reg, shadow_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [FAIL_W-1:0]     fail_cnt_reg, fail_cnt_next;
  logic                  pass_reg, pass_next;
  logic [KEY_WIDTH-1:0]  key_out_reg, key_out_next;
  logic                  key_valid_reg, key_valid_next;
  logic                  load_ok_reg, load_ok_next;
  logic                  load_err_reg, load_err_next;

  logic [KEY_WIDTH-1:0]  bit_sel;
  logic                  xfer;
  logic [FAIL_W-1:0]     fail_inc;

  // One-hot decode of the shadow bit addressed by the current bit count.
  generate
    for (genvar gi = 0; gi < KEY_WIDTH; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (bit_cnt_reg == CNT_W'(gi));
    end
  endgenerate

  assign key_sready = (state_reg == S_SHIFT) || (state_reg == S_PARITY);
  assign busy       = (state_reg == S_SHIFT) || (state_reg == S_PARITY) ||
                      (state_reg == S_CHECK);
  assign locked_out = (state_reg == S_LOCKOUT);
  assign key_out    = key_out_reg;
  assign key_valid  = key_valid_reg;
  assign load_ok    = load_ok_reg;
  assign load_err   = load_err_reg;

  assign xfer     = key_svalid & key_sready;
  assign fail_inc = fail_cnt_reg + FAIL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      shadow_reg    <= '0;
      bit_cnt_reg   <= '0;
      fail_cnt_reg  <= '0;
      pass_reg      <= 1'b0;
      key_out_reg   <= '0;
      key_valid_reg <= 1'b0;
      load_ok_reg   <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shadow_reg    <= shadow_next;
      bit_cnt_reg   <= bit_cnt_next;
      fail_cnt_reg  <= fail_cnt_next;
      pass_reg      <= pass_next;
      key_out_reg   <= key_out_next;
      key_valid_reg <= key_valid_next;
      load_ok_reg   <= load_ok_next;
      load_err_reg  <= load_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shadow_next    = shadow_reg;
    bit_cnt_next   = bit_cnt_reg;
    fail_cnt_next  = fail_cnt_reg;
    pass_next      = pass_reg;
    key_out_next   = key_out_reg;
    key_valid_next = key_valid_reg;
    load_ok_next   = 1'b0;
    load_err_next  = 1'b0;

    // Zeroize outranks everything except the lockout, which only reset can leave.
    if (zeroize && (state_reg != S_LOCKOUT)) begin
      state_next     = S_IDLE;
      shadow_next    = '0;
      bit_cnt_next   = '0;
      key_out_next   = '0;
      key_valid_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (load_start) begin
            state_next     = S_SHIFT;
            shadow_next    = '0;
            bit_cnt_next   = '0;
            key_valid_next = 1'b0;
          end
        end
        S_SHIFT: begin
          if (xfer) begin
            shadow_next  = (shadow_reg & ~bit_sel) | (bit_sel & {KEY_WIDTH{key_sdi}});
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            if (bit_cnt_reg == CNT_W'(KEY_WIDTH - 1)) begin
              state_next = S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (xfer) begin
            pass_next  = (key_sdi == ^shadow_reg);
            state_next = S_CHECK;
          end
        end
        S_CHECK: begin
          if (pass_reg) begin
            key_out_next   = shadow_reg;
            key_valid_next = 1'b1;
            fail_cnt_next  = '0;
            load_ok_next   = 1'b1;
            state_next     = S_IDLE;
          end else begin
            key_out_next   = '0;
            key_valid_next = 1'b0;
            fail_cnt_next  = fail_inc;
            load_err_next  = 1'b1;
            state_next     = (fail_inc == FAIL_W'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
          end
        end
        S_LOCKOUT: begin
          key_out_next   = '0;
          key_valid_next = 1'b0;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// Randomized bench for lock_key_loader: a frame-level reference model is stepped on
// each clock and every output is compared against it on every falling edge.
module tb_lock_key_loader;
  localparam int KW = 32;
  localparam int MF = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          key_sdi = 1'b0;
  logic          key_svalid = 1'b0;
  logic          key_sready;
  logic          zeroize = 1'b0;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          busy;
  logic          load_ok;
  logic          load_err;
  logic          locked_out;

  lock_key_loader #(.KEY_WIDTH(KW), .MAX_FAIL(MF)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .key_sdi(key_sdi),
    .key_svalid(key_svalid), .key_sready(key_sready), .zeroize(zeroize),
    .key_out(key_out), .key_valid(key_valid), .busy(busy), .load_ok(load_ok),
    .load_err(load_err), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int ok_seen = 0;
  int err_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is either being received, awaiting its verdict, or absent.
  bit          m_active, m_pending, m_pass, m_locked, m_valid, m_ok, m_err;
  int          m_n, m_fails;
  logic [KW-1:0] m_data, m_key;

  task automatic model_reset();
    m_active = 0; m_pending = 0; m_pass = 0; m_locked = 0;
    m_valid = 0; m_ok = 0; m_err = 0; m_n = 0; m_fails = 0;
    m_data = '0; m_key = '0;
  endtask

  task automatic model_step(input bit ls, input bit sdi, input bit sv, input bit zr);
    m_ok = 0;
    m_err = 0;
    if (m_locked) return;
    if (zr) begin
      m_active = 0; m_pending = 0; m_n = 0; m_data = '0;
      m_key = '0; m_valid = 0;
    end else if (m_pending) begin
      m_pending = 0;
      m_active = 0;
      if (m_pass) begin
        m_key = m_data; m_valid = 1; m_fails = 0; m_ok = 1;
      end else begin
        m_key = '0; m_valid = 0; m_fails++; m_err = 1;
        if (m_fails == MF) m_locked = 1;
      end
    end else if (m_active) begin
      if (sv) begin
        if (m_n < KW) begin
          m_data[m_n] = sdi;
          m_n++;
        end else begin
          m_pass = ((($countones(m_data) + int'(sdi)) % 2) == 0);
          m_pending = 1;
        end
      end
    end else if (ls) begin
      m_active = 1; m_valid = 0; m_n = 0; m_data = '0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step(load_start, key_sdi, key_svalid, zeroize);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("key_out", 64'(key_out), 64'(m_locked ? '0 : m_key));
      chk("key_valid", 64'(key_valid), 64'(m_valid && !m_locked));
      chk("key_sready", 64'(key_sready), 64'(m_active && !m_pending && !m_locked));
      chk("busy", 64'(busy), 64'(m_active && !m_locked));
      chk("load_ok", 64'(load_ok), 64'(m_ok));
      chk("load_err", 64'(load_err), 64'(m_err));
      chk("locked_out", 64'(locked_out), 64'(m_locked));
      if (load_ok) ok_seen++;
      if (load_err) err_seen++;
    end
  end

  // Sends a frame; nbits limits how many bits go out, zat >= 0 zeroizes at that bit.
  task automatic send_frame(input logic [KW-1:0] d, input bit par, input int gap,
                            input int zat, input int nbits, input bit stray_ls);
    bit b, hs;
    int guard;
    key_svalid = 0;
    load_start = 1;
    @(negedge clk);
    load_start = 0;
    for (int i = 0; i <= KW && i < nbits; i++) begin
      b = (i < KW) ? d[i] : par;
      guard = 0;
      forever begin
        if (i == zat) begin
          zeroize = 1;
          key_svalid = 1;
          key_sdi = b;
          @(negedge clk);
          zeroize = 0;
          key_svalid = 0;
          $display("frame zeroized at bit %0d", i);
          return;
        end
        key_svalid = ($urandom_range(99) >= gap);
        key_sdi = key_svalid ? b : 1'($urandom_range(1));
        load_start = stray_ls && ($urandom_range(19) == 0);
        hs = key_svalid && key_sready;
        @(negedge clk);
        load_start = 0;
        if (hs) break;
        guard++;
        if (guard > 200) begin
          errors++;
          checks++;
          $display("FAIL handshake_timeout actual=stalled required=accept bit %0d", i);
          key_svalid = 0;
          return;
        end
      end
    end
    key_svalid = 0;
    if (nbits > KW) begin
      repeat (3) @(negedge clk);
      #1;
    end
    $display("frame data=%h par=%0d gap=%0d -> key_out=%h valid=%0d ok=%0d err=%0d locked=%0d",
             d, par, gap, key_out, key_valid, ok_seen, err_seen, locked_out);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_key_out", 64'(key_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sready", 64'(key_sready), 64'd0);
    chk("rst_locked", 64'(locked_out), 64'd0);
    chk("rst_valid", 64'(key_valid), 64'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  int ok0, err0;
  logic [KW-1:0] rd;

  initial begin
    model_reset();
    #12;
    chk("init_key_out", 64'(key_out), 64'd0);
    chk("init_sready", 64'(key_sready), 64'd0);
    chk("init_locked", 64'(locked_out), 64'd0);
    @(negedge clk);
    rst_n = 1;
    cmp_en = 1;
    @(negedge clk);

    // 1: good frame
    ok0 = ok_seen;
    send_frame(32'hA5A50F0F, 1'b0, 0, -1, KW + 1, 0);
    chk("t1_key", 64'(key_out), 64'hA5A50F0F);
    chk("t1_valid", 64'(key_valid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_okcnt", 64'(ok_seen - ok0), 64'd1);

    // 2: bad parity, then good key 1
    err0 = err_seen;
    send_frame(32'hA5A50F0F, 1'b1, 0, -1, KW + 1, 0);
    chk("t2_errcnt", 64'(err_seen - err0), 64'd1);
    chk("t2_key", 64'(key_out), 64'd0);
    chk("t2_valid", 64'(key_valid), 64'd0);
    send_frame(32'h00000001, 1'b1, 0, -1, KW + 1, 0);
    chk("t2_key1", 64'(key_out), 64'h1);

    // 3: three bad frames lock out
    send_frame(32'h12345678, ~(^32'h12345678), 10, -1, KW + 1, 0);
    send_frame(32'h0, 1'b1, 10, -1, KW + 1, 0);
    chk("t3_not_yet", 64'(locked_out), 64'd0);
    send_frame(32'hFFFF0000, 1'b1, 10, -1, KW + 1, 0);
    chk("t3_locked", 64'(locked_out), 64'd1);
    load_start = 1;
    zeroize = 1;
    @(negedge clk);
    load_start = 0;
    zeroize = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("t3_sready", 64'(key_sready), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_still_locked", 64'(locked_out), 64'd1);
    do_reset();
    #1 chk("t3_unlocked", 64'(locked_out), 64'd0);

    // 4: gappy handshakes
    send_frame(32'hDEADBEEF, 1'b0, 50, -1, KW + 1, 1);
    chk("t4_key", 64'(key_out), 64'hDEADBEEF);

    // 5: zeroize mid-frame, then bad/bad/good/bad
    ok0 = ok_seen;
    err0 = err_seen;
    send_frame(32'hCAFEF00D, ^32'hCAFEF00D, 0, 10, KW + 1, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("t5_zkey", 64'(key_out), 64'd0);
    chk("t5_nopulse", 64'(ok_seen - ok0 + err_seen - err0), 64'd0);
    send_frame(32'h1, 1'b0, 20, -1, KW + 1, 0);
    send_frame(32'h3, 1'b1, 20, -1, KW + 1, 0);
    send_frame(32'h7, 1'b1, 20, -1, KW + 1, 0);
    send_frame(32'hF, 1'b1, 20, -1, KW + 1, 0);
    chk("t5_nolock", 64'(locked_out), 64'd0);

    // 6: async reset mid-shift
    send_frame(32'h55AA55AA, 1'b0, 0, -1, 12, 0);
    do_reset();
    send_frame(32'h0F0F0F0F, 1'b0, 0, -1, KW + 1, 0);
    chk("t6_key", 64'(key_out), 64'h0F0F0F0F);

    // Random frames
    for (int f = 0; f < 30; f++) begin
      rd = $urandom;
      send_frame(rd, ($urandom_range(99) < 65) ? ^rd : ~(^rd), $urandom_range(60),
                 ($urandom_range(99) < 15) ? int'($urandom_range(KW)) : -1,
                 KW + 1, 1);
      repeat ($urandom_range(3)) @(negedge clk);
      if (m_locked) do_reset();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
